// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: packet-level round-robin arbiter sharing one router injection port.
// A grant is held from head to tail flit, and flits are only accepted while downstream credits remain.
module noc_inject_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                                   clk_noc,
    input  logic                                   rst_noc_sync,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ-1:0][FLIT_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ-1:0][DEST_WIDTH-1:0]     req_dest,
    input  logic [NUM_REQ-1:0]                     req_is_tail,
    output logic [FLIT_WIDTH-1:0]                  data_out,
    output logic [DEST_WIDTH-1:0]                  dest_out,
    output logic                                   is_tail_out,
    output logic                                   send_out,
    input  logic                                   credit_in,
    output logic [$clog2(NUM_REQ)-1:0]             grant_id,
    output logic [CREDIT_WIDTH-1:0]                credit_count,
    output logic                                   busy,
    output logic                                   credit_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CREDIT_WIDTH-1:0] FULL_CREDITS = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IDX_W-1:0]        owner_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        grant_q;
    logic [CREDIT_WIDTH-1:0] credit_q;
    logic                    credit_err_q;
    logic [FLIT_WIDTH-1:0]   data_q;
    logic [DEST_WIDTH-1:0]   dest_q;
    logic                    tail_q;
    logic                    send_q;

    logic                    can_send;
    logic                    found;
    logic                    accept;
    logic                    acc_tail;
    logic [IDX_W-1:0]        pick;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W-1:0]        acc_idx;

    // Only the registered count gates sending; a same-cycle credit_in is not bypassed.
    assign can_send = (credit_q != '0);

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In LOCKED only the owner may move, even while it stalls mid-packet.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        acc_idx   = owner_q;
        if (!rst_noc_sync && can_send) begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        accept  = 1'b1;
                        acc_idx = pick;
                    end
                end
                LOCKED: begin
                    accept = req_valid[owner_q];
                end
                default: begin
                    accept = 1'b0;
                end
            endcase
        end
        if (accept) begin
            req_ready[acc_idx] = 1'b1;
            state_d = req_is_tail[acc_idx] ? IDLE : LOCKED;
        end
    end

    assign acc_tail = req_is_tail[acc_idx];

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            credit_q     <= FULL_CREDITS;
            credit_err_q <= 1'b0;
            data_q       <= '0;
            dest_q       <= '0;
            tail_q       <= 1'b0;
            send_q       <= 1'b0;
        end else begin
            send_q <= accept;
            if (accept) begin
                data_q  <= req_data[acc_idx];
                dest_q  <= req_dest[acc_idx];
                tail_q  <= acc_tail;
                owner_q <= acc_idx;
                grant_q <= acc_idx;
                if (acc_tail) begin
                    rr_ptr_q <= (acc_idx == LAST_IDX) ? '0 : acc_idx + IDX_W'(1);
                end
            end
            // A return at full count means the router sent back more credits than it owns.
            if (accept && !credit_in) begin
                credit_q <= credit_q - CREDIT_WIDTH'(1);
            end else if (credit_in && !accept) begin
                if (credit_q == FULL_CREDITS) begin
                    credit_err_q <= 1'b1;
                end else begin
                    credit_q <= credit_q + CREDIT_WIDTH'(1);
                end
            end
        end
    end

    assign data_out     = data_q;
    assign dest_out     = dest_q;
    assign is_tail_out  = tail_q;
    assign send_out     = send_q;
    assign grant_id     = grant_q;
    assign credit_count = credit_q;
    assign busy         = (state_q == LOCKED);
    assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed self-checking bench for noc_inject_arbiter with default parameters.
// Inputs change 1 time unit after the rising edge; registered outputs are checked there too.
module tb_noc_inject_arbiter;

    logic              clk_noc;
    logic              rst_noc_sync;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [3:0][31:0]  req_data;
    logic [3:0][3:0]   req_dest;
    logic [3:0]        req_is_tail;
    logic [31:0]       data_out;
    logic [3:0]        dest_out;
    logic              is_tail_out;
    logic              send_out;
    logic              credit_in;
    logic [1:0]        grant_id;
    logic [3:0]        credit_count;
    logic              busy;
    logic              credit_err;

    int n_checks = 0;
    int n_fail   = 0;

    noc_inject_arbiter dut (
        .clk_noc      (clk_noc),
        .rst_noc_sync (rst_noc_sync),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_dest     (req_dest),
        .req_is_tail  (req_is_tail),
        .data_out     (data_out),
        .dest_out     (dest_out),
        .is_tail_out  (is_tail_out),
        .send_out     (send_out),
        .credit_in    (credit_in),
        .grant_id     (grant_id),
        .credit_count (credit_count),
        .busy         (busy),
        .credit_err   (credit_err)
    );

    initial clk_noc = 1'b0;
    always #5 clk_noc = ~clk_noc;

    function automatic logic [31:0] flit(int r, int k);
        return 32'hA000_0000 | 32'(r << 8) | 32'(k);
    endfunction

    task automatic step();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_is_tail = '0;
        req_data    = '0;
        credit_in   = 1'b0;
        for (int i = 0; i < 4; i++) req_dest[i] = 4'(i + 4);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_noc_sync = 1'b1;
        step();
        step();
        rst_noc_sync = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_noc_sync = 1'b1;
        req_valid    = 4'b1111;
        req_is_tail  = 4'b1111;
        step();
        step();
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_ready: got %b expected 0000", req_ready); end
        n_checks++; if (credit_count !== 4'd8) begin n_fail++; $display("[TB] FAIL rst_credit: got %0d expected 8", credit_count); end
        n_checks++; if (send_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_send: got %b expected 0", send_out); end
        n_checks++; if (busy !== 1'b0 || credit_err !== 1'b0 || is_tail_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_flags: busy=%b err=%b tail=%b expected all 0", busy, credit_err, is_tail_out); end
        n_checks++; if (grant_id !== 2'd0 || data_out !== 32'd0 || dest_out !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_regs: grant=%0d data=%h dest=%h expected 0", grant_id, data_out, dest_out); end
        rst_noc_sync = 1'b0;
        clear_inputs();
        step();
        n_checks++; if (send_out !== 1'b0 || credit_count !== 4'd8) begin n_fail++; $display("[TB] FAIL idle_after_rst: send=%b credit=%0d expected 0/8", send_out, credit_count); end
    endtask

    task automatic test_single_packet();
        do_reset();
        credit_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_valid      = 4'b0100;
            req_data[2]    = flit(2, c);
            req_is_tail[2] = (c == 2);
            #1;
            n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL sp_ready%0d: got %b expected 0100", c, req_ready); end
            step();
            n_checks++; if (send_out !== 1'b1 || data_out !== flit(2, c) || dest_out !== 4'd6) begin n_fail++; $display("[TB] FAIL sp_flit%0d: send=%b data=%h dest=%h expected 1/%h/6", c, send_out, data_out, dest_out, flit(2, c)); end
            n_checks++; if (is_tail_out !== (c == 2) || busy !== (c < 2) || grant_id !== 2'd2) begin n_fail++; $display("[TB] FAIL sp_state%0d: tail=%b busy=%b grant=%0d expected %b/%b/2", c, is_tail_out, busy, grant_id, c == 2, c < 2); end
            n_checks++; if (credit_count !== 4'd8) begin n_fail++; $display("[TB] FAIL sp_credit%0d: got %0d expected 8", c, credit_count); end
        end
        clear_inputs();
        step();
        n_checks++; if (send_out !== 1'b0 || data_out !== flit(2, 2) || is_tail_out !== 1'b1) begin n_fail++; $display("[TB] FAIL sp_hold: send=%b data=%h tail=%b expected 0/%h/1", send_out, data_out, is_tail_out, flit(2, 2)); end
        req_valid   = 4'b1111;
        req_is_tail = 4'b1111;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL sp_rrptr: got %b expected 1000", req_ready); end
        clear_inputs();
        step();
    endtask

    task automatic test_contention();
        int exp_req[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int exp_flit[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 4};
        int cnt0 = 0;
        int cnt1 = 0;
        do_reset();
        credit_in = 1'b1;
        for (int c = 0; c < 9; c++) begin
            req_valid[0]   = (cnt0 < 5);
            req_data[0]    = flit(0, cnt0);
            req_is_tail[0] = (cnt0 >= 3);
            req_valid[1]   = (cnt1 < 4);
            req_data[1]    = flit(1, cnt1);
            req_is_tail[1] = (cnt1 == 3);
            #1;
            n_checks++; if (req_ready !== (4'b0001 << exp_req[c])) begin n_fail++; $display("[TB] FAIL ct_ready%0d: got %b expected %b", c, req_ready, 4'b0001 << exp_req[c]); end
            if (req_ready[0]) cnt0++;
            if (req_ready[1]) cnt1++;
            step();
            n_checks++; if (send_out !== 1'b1 || data_out !== flit(exp_req[c], exp_flit[c])) begin n_fail++; $display("[TB] FAIL ct_data%0d: send=%b data=%h expected 1/%h", c, send_out, data_out, flit(exp_req[c], exp_flit[c])); end
        end
        clear_inputs();
        do_reset();
        begin
            logic [3:0] exp_rdy[4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
            int exp_g[4] = '{0, 1, 3, 0};
            credit_in   = 1'b1;
            req_valid   = 4'b1011;
            req_is_tail = 4'b1111;
            for (int i = 0; i < 4; i++) req_data[i] = flit(i, 0);
            for (int c = 0; c < 4; c++) begin
                #1;
                n_checks++; if (req_ready !== exp_rdy[c]) begin n_fail++; $display("[TB] FAIL rr_ready%0d: got %b expected %b", c, req_ready, exp_rdy[c]); end
                step();
                n_checks++; if (grant_id !== 2'(exp_g[c]) || busy !== 1'b0 || data_out !== flit(exp_g[c], 0)) begin n_fail++; $display("[TB] FAIL rr_grant%0d: grant=%0d busy=%b data=%h expected %0d/0/%h", c, grant_id, busy, data_out, exp_g[c], flit(exp_g[c], 0)); end
            end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_credit_exhaustion();
        int k = 0;
        do_reset();
        req_valid = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            req_data[1] = flit(1, k);
            #1;
            n_checks++; if (req_ready !== ((c < 8) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("[TB] FAIL ce_ready%0d: got %b expected %b", c, req_ready, (c < 8) ? 4'b0010 : 4'b0000); end
            if (req_ready[1]) k++;
            step();
            n_checks++; if (credit_count !== ((c < 8) ? 4'(7 - c) : 4'd0)) begin n_fail++; $display("[TB] FAIL ce_count%0d: got %0d expected %0d", c, credit_count, (c < 8) ? 7 - c : 0); end
        end
        n_checks++; if (busy !== 1'b1 || send_out !== 1'b0) begin n_fail++; $display("[TB] FAIL ce_stall: busy=%b send=%b expected 1/0", busy, send_out); end
        credit_in   = 1'b1;
        req_data[1] = flit(1, 8);
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL ce_nobypass: got %b expected 0000", req_ready); end
        step();
        credit_in = 1'b0;
        n_checks++; if (credit_count !== 4'd1 || send_out !== 1'b0) begin n_fail++; $display("[TB] FAIL ce_credit1: count=%0d send=%b expected 1/0", credit_count, send_out); end
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL ce_ready_after: got %b expected 0010", req_ready); end
        step();
        n_checks++; if (send_out !== 1'b1 || data_out !== flit(1, 8) || credit_count !== 4'd0) begin n_fail++; $display("[TB] FAIL ce_extra: send=%b data=%h count=%0d expected 1/%h/0", send_out, data_out, credit_count, flit(1, 8)); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL ce_ready_end: got %b expected 0000", req_ready); end
        step();
        n_checks++; if (send_out !== 1'b0) begin n_fail++; $display("[TB] FAIL ce_one_only: send=%b expected 0", send_out); end
        clear_inputs();
    endtask

    task automatic test_credit_simultaneous();
        do_reset();
        req_valid   = 4'b0001;
        req_is_tail = 4'b0001;
        for (int j = 0; j < 3; j++) begin
            req_data[0] = flit(0, j);
            step();
        end
        n_checks++; if (credit_count !== 4'd5) begin n_fail++; $display("[TB] FAIL cs_five: got %0d expected 5", credit_count); end
        credit_in = 1'b1;
        step();
        n_checks++; if (credit_count !== 4'd5 || send_out !== 1'b1) begin n_fail++; $display("[TB] FAIL cs_both: count=%0d send=%b expected 5/1", credit_count, send_out); end
        req_valid = 4'b0000;
        step();
        step();
        step();
        n_checks++; if (credit_count !== 4'd8 || credit_err !== 1'b0) begin n_fail++; $display("[TB] FAIL cs_refill: count=%0d err=%b expected 8/0", credit_count, credit_err); end
        step();
        credit_in = 1'b0;
        n_checks++; if (credit_count !== 4'd8 || credit_err !== 1'b1) begin n_fail++; $display("[TB] FAIL cs_overflow: count=%0d err=%b expected 8/1", credit_count, credit_err); end
        step();
        n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("[TB] FAIL cs_sticky: err=%b expected 1", credit_err); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        credit_in   = 1'b1;
        req_valid   = 4'b0001;
        for (int j = 0; j < 2; j++) begin
            req_data[0] = flit(0, j);
            step();
        end
        n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("[TB] FAIL rm_locked: busy=%b grant=%0d expected 1/0", busy, grant_id); end
        rst_noc_sync = 1'b1;
        req_data[0]  = flit(0, 2);
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL rm_ready_in_rst: got %b expected 0000", req_ready); end
        step();
        n_checks++; if (busy !== 1'b0 || credit_count !== 4'd8 || send_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_abort: busy=%b count=%0d send=%b expected 0/8/0", busy, credit_count, send_out); end
        rst_noc_sync   = 1'b0;
        credit_in      = 1'b0;
        req_valid      = 4'b0100;
        req_data[2]    = flit(2, 9);
        req_is_tail[2] = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL rm_new_ready: got %b expected 0100", req_ready); end
        step();
        n_checks++; if (send_out !== 1'b1 || data_out !== flit(2, 9) || grant_id !== 2'd2 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_new_pkt: send=%b data=%h grant=%0d busy=%b expected 1/%h/2/0", send_out, data_out, grant_id, busy, flit(2, 9)); end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        rst_noc_sync = 1'b1;
        test_reset();
        test_single_packet();
        test_contention();
        test_credit_exhaustion();
        test_credit_simultaneous();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Packet-level round-robin arbiter that shares one router injection port among `NUM_REQ` flit-level requesters, such as several serializer shims or user engines feeding local port 0 of a mesh router. It holds the grant from a packet's first flit through its tail, so packets never interleave. It tracks the router input buffer's free slots with a credit counter and presents registered `data/dest/is_tail/send` outputs that connect directly to the router's input port.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..16).
- `FLIT_WIDTH`, 32: flit payload width.
- `DEST_WIDTH`, 4: destination field width ({tid, tdest}).
- `FLIT_BUFFER_DEPTH`, 8: downstream input buffer depth; initial credit count.
- `CREDIT_WIDTH`, `$clog2(FLIT_BUFFER_DEPTH+1)`: credit counter width.

Ports:
- `clk_noc` in 1: clock. One clock; all logic is on this clock.
- `rst_noc_sync` in 1: reset, synchronous, active-high.
- `req_valid` in `[NUM_REQ]`: requester i has a flit.
- `req_ready` out `[NUM_REQ]`: flit i is accepted this cycle (combinational).
- `req_data` in `[NUM_REQ][FLIT_WIDTH]`: flit payload.
- `req_dest` in `[NUM_REQ][DEST_WIDTH]`: destination; sampled on every flit.
- `req_is_tail` in `[NUM_REQ]`: last flit of the packet.
- `data_out` out `FLIT_WIDTH`: registered flit to the router.
- `dest_out` out `DEST_WIDTH`: registered destination.
- `is_tail_out` out 1: registered tail flag.
- `send_out` out 1: flit valid, one-cycle pulse per flit.
- `credit_in` in 1: router freed one buffer slot.
- `grant_id` out `$clog2(NUM_REQ)`: current or last owner.
- `credit_count` out `CREDIT_WIDTH`: current credit count.
- `busy` out 1: the FSM is in LOCKED.
- `credit_err` out 1: sticky; set when a credit is returned while the count is already at `FLIT_BUFFER_DEPTH`.

## Operation
- FSM states: IDLE, LOCKED(owner).
- `can_send` = (`credit_count` != 0). It uses the registered count only; a `credit_in` arriving in the same cycle is not bypassed.
- IDLE behaviour:
  - If `can_send` and any `req_valid`, grant the first valid index searching from `rr_ptr` upward, wrapping modulo `NUM_REQ`.
  - `req_ready[g]`=1 for the granted index only; the flit transfers in this cycle.
  - If the accepted flit has `is_tail`=0, go to LOCKED(g).
  - If `is_tail`=1 (single-flit packet), stay in IDLE.
  - In both cases `rr_ptr` becomes `(g+1) mod NUM_REQ` on the tail.
- LOCKED(o) behaviour:
  - `req_ready[o]` = `req_valid[o]` & `can_send`. All other `req_ready` are 0, even if the owner is idle.
  - Accepting a tail returns the FSM to IDLE and sets `rr_ptr` = `(o+1) mod NUM_REQ`.
- Every accepted flit is registered into `data_out/dest_out/is_tail_out`, and `send_out` is asserted for exactly one cycle. The output registers hold their last value when `send_out`=0.
- Credit counter update per cycle:
  - Decrement by 1 on accept.
  - Increment by 1 on `credit_in`.
  - Both in the same cycle: unchanged.
  - At `FLIT_BUFFER_DEPTH` with `credit_in` and no accept: saturate and set `credit_err`.
- Throughput: at most one flit per cycle; back-to-back flits of one packet are sustained while credits last.
- Mid-packet owner stalls (`req_valid[o]`=0) do not release the grant.

## Timing
- Accept at cycle T: `send_out`, `data_out` and `is_tail_out` are valid at T+1. Latency is 1 cycle.
- Counters: `credit_count` reflects the accept or `credit_in` of cycle T at T+1. `busy` and `grant_id` update at T+1.
- If the count is 0 at T and `credit_in` arrives at T, the earliest accept is at T+1.
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `credit_count` = `FLIT_BUFFER_DEPTH`, `send_out`/`is_tail_out`/`busy`/`credit_err` 0, `data_out`/`dest_out` 0. `req_ready` is all 0 while `rst_noc_sync`=1.
- Reset mid-packet: the FSM aborts to IDLE and credits restore to full. The partial packet is not completed; upstream and the router must be reset together.

## Test plan
- Reset then idle: after reset, `credit_count`=8, `send_out`=0, `req_ready`=0 during reset.
- Single packet: requester 2 sends 3 flits (tail on the third) with credits returned.
  - `send_out` pulses at cycles T+1..T+3 with matching data.
  - `busy` is 1 after the first flit and 0 after the tail.
  - `rr_ptr` becomes 3.
- Contention: requesters 0 and 1 each send one 4-flit packet, starting simultaneously.
  - All 4 flits of req0 go out before any flit of req1.
  - Next round, with both valid, req1 wins.
  - Single-flit packets from 0,1,3 with all valid: grants go 0,1,3,0.
- Credit exhaustion: `credit_in`=0, 10-flit packet.
  - Exactly 8 flits are sent, then `req_ready`=0 and `credit_count`=0.
  - One `credit_in` pulse yields exactly 1 more flit, one cycle later.
- Simultaneous accept and credit at `credit_count`=5: the count stays 5. A credit pulse at count 8 sets `credit_err`=1 and the count stays 8.
- Reset mid-packet: assert `rst_noc_sync` after flit 2 of 4.
  - Next cycle: `busy`=0, credits=8, `send_out`=0.
  - A new packet from another requester is granted right after reset is released.
